bitwise_pipe: RTL and testbench



---
 rtl/bitwise_pkg.sv | 18 +
 rtl/pipe_slice.sv | 37 +++
 rtl/bitwise_pipe.sv | 83 ++++++++
 tb/tb_bitwise_pipe.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bitwise_pkg.sv
// Shared definitions for the pipelined bitwise logic unit.
// Operation encoding used by the compute stage and by any block that issues ops.
package bitwise_pkg;

   localparam int OP_W = 3;

   typedef enum logic [OP_W-1:0] {
      OP_NOT  = 3'b000,
      OP_AND  = 3'b001,
      OP_OR   = 3'b010,
      OP_XOR  = 3'b011,
      OP_NAND = 3'b100,
      OP_NOR  = 3'b101,
      OP_XNOR = 3'b110,
      OP_PASS = 3'b111
   } op_e;

endpackage

// File: rtl/pipe_slice.sv
// One elastic register slice: a single-entry buffer with valid/ready handshake.
// Loads whenever it is empty or its downstream consumer takes the current entry.
module pipe_slice #(
   parameter int W = 18
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         up_valid,
   output logic         up_ready,
   input  logic [W-1:0] up_data,
   output logic         dn_valid,
   input  logic         dn_ready,
   output logic [W-1:0] dn_data
);

   logic         valid_q;
   logic [W-1:0] data_q;

   assign up_ready = !valid_q || dn_ready;

   // Payload only moves on a real upstream transfer, so idle inputs never leak in.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else if (up_ready) begin
         valid_q <= up_valid;
         if (up_valid) begin
            data_q <= up_data;
         end
      end
   end

   assign dn_valid = valid_q;
   assign dn_data  = data_q;

endmodule

// File: rtl/bitwise_pipe.sv
// Pipelined bitwise logic unit: op decode and flags up front, then a chain of
// STAGES elastic slices carrying {result, zero, neg} to the consumer.
module bitwise_pipe
   import bitwise_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [OP_W-1:0]  op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             out_zero,
   output logic             out_neg
);

   localparam int PW = WIDTH + 2;

   logic [WIDTH-1:0] res;
   logic [PW-1:0]    payload;

   always_comb begin
      res = a;
      case (op)
         OP_NOT:  res = ~a;
         OP_AND:  res = a & b;
         OP_OR:   res = a | b;
         OP_XOR:  res = a ^ b;
         OP_NAND: res = ~(a & b);
         OP_NOR:  res = ~(a | b);
         OP_XNOR: res = ~(a ^ b);
         OP_PASS: res = a;
      endcase
   end

   assign payload = {res, (res == '0), res[WIDTH-1]};

   // Each slice keeps its own handshake wires so the ready chain stays acyclic per signal.
   for (genvar k = 0; k < STAGES; k++) begin : g_slice
      logic          up_valid;
      logic          up_ready;
      logic          dn_valid;
      logic          dn_ready;
      logic [PW-1:0] up_data;
      logic [PW-1:0] dn_data;

      if (k == 0) begin : g_head
         assign up_valid = in_valid;
         assign up_data  = payload;
      end else begin : g_link
         assign up_valid = g_slice[k-1].dn_valid;
         assign up_data  = g_slice[k-1].dn_data;
      end

      if (k == STAGES - 1) begin : g_tail
         assign dn_ready = out_ready;
      end else begin : g_next
         assign dn_ready = g_slice[k+1].up_ready;
      end

      pipe_slice #(.W(PW)) u_slice (
         .clk      (clk),
         .rst      (rst),
         .up_valid (up_valid),
         .up_ready (up_ready),
         .up_data  (up_data),
         .dn_valid (dn_valid),
         .dn_ready (dn_ready),
         .dn_data  (dn_data)
      );
   end

   assign in_ready                 = g_slice[0].up_ready;
   assign out_valid                = g_slice[STAGES-1].dn_valid;
   assign {out, out_zero, out_neg} = g_slice[STAGES-1].dn_data;

endmodule

// File: tb/tb_bitwise_pipe.sv
// Self-checking bench for bitwise_pipe: queue scoreboard on a 16-bit/2-stage
// instance plus directed literal checks, and a small 8-bit/1-stage instance.
module tb_bitwise_pipe;
   import bitwise_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        in_valid, in_ready, out_valid, out_ready, out_zero, out_neg;
   logic [2:0]  op;
   logic [15:0] a, b, out;

   bitwise_pipe #(.WIDTH(16), .STAGES(2)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
      .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .out(out),
      .out_zero(out_zero), .out_neg(out_neg));

   logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_out_zero, s_out_neg;
   logic [2:0]  s_op;
   logic [7:0]  s_a, s_b, s_out;

   bitwise_pipe #(.WIDTH(8), .STAGES(1)) dut8 (
      .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .op(s_op),
      .a(s_a), .b(s_b), .out_valid(s_out_valid), .out_ready(s_out_ready), .out(s_out),
      .out_zero(s_out_zero), .out_neg(s_out_neg));

   int n_pass  = 0;
   int n_total = 0;
   int cyc     = 0;
   logic strict_lat;

   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [15:0] d;
      int          cyc;
   } item_t;

   item_t exp_q[$];
   item_t got_q[$];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, got, exp);
   endtask

   // Reference behaviour: the operation table applied directly to the operands.
   function automatic logic [15:0] model(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y);
      case (o)
         3'd0:    return ~x;
         3'd1:    return x & y;
         3'd2:    return x | y;
         3'd3:    return x ^ y;
         3'd4:    return ~(x & y);
         3'd5:    return ~(x | y);
         3'd6:    return ~(x ^ y);
         default: return x;
      endcase
   endfunction

   logic [15:0] h_out;
   logic        h_hold = 1'b0;

   always @(negedge clk) begin
      item_t it;
      if (rst) begin
         exp_q.delete();
         h_hold = 1'b0;
      end else begin
         if (h_hold) begin
            chk("hold_valid", out_valid, 1'b1);
            chk("hold_out", out, h_out);
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               n_total++;
               $display("FAIL unexpected_out: got %h with no result outstanding", out);
            end else begin
               it = exp_q.pop_front();
               chk("out", out, it.d);
               chk("out_zero", out_zero, (it.d == 16'h0));
               chk("out_neg", out_neg, it.d[15]);
               if (strict_lat) chk("latency", cyc - it.cyc, 2);
            end
            it.d = out; it.cyc = cyc;
            got_q.push_back(it);
         end
         if (in_valid && in_ready) begin
            it.d = model(op, a, b); it.cyc = cyc;
            exp_q.push_back(it);
         end
         h_hold = out_valid && !out_ready;
         h_out  = out;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_lit(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y,
                           input logic [15:0] e, input logic z, input logic n);
      op = o; a = x; b = y; in_valid = 1'b1;
      @(negedge clk);
      chk("lit_in_ready", in_ready, 1'b1);
      step();
      in_valid = 1'b0;
      @(negedge clk);
      chk("lit_not_early", out_valid, 1'b0);
      step();
      @(negedge clk);
      chk("lit_valid", out_valid, 1'b1);
      chk("lit_out", out, e);
      chk("lit_zero", out_zero, z);
      chk("lit_neg", out_neg, n);
      step();
   endtask

   task automatic push_item(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y);
      op = o; a = x; b = y; in_valid = 1'b1;
      @(negedge clk);
      chk("push_in_ready", in_ready, 1'b1);
      step();
      in_valid = 1'b0;
   endtask

   logic [15:0] lit8 [8];

   initial begin
      lit8 = '{16'hFF00, 16'h000F, 16'h0FFF, 16'h0FF0, 16'hFFF0, 16'hF000, 16'hF00F, 16'h00FF};
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = 3'd0; a = '0; b = '0;
      s_in_valid = 1'b0; s_out_ready = 1'b1; s_op = 3'd0; s_a = '0; s_b = '0;
      strict_lat = 1'b1;
      repeat (2) step();
      rst = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out", out, 16'h0);
      chk("rst_zero", out_zero, 1'b0);
      chk("rst_neg", out_neg, 1'b0);
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst8_out_valid", s_out_valid, 1'b0);
      chk("rst8_in_ready", s_in_ready, 1'b1);
      step();

      // NOT sweep with literal results, two-cycle latency
      send_lit(OP_NOT, 16'h0000, 16'h0, 16'hFFFF, 1'b0, 1'b1);
      send_lit(OP_NOT, 16'hFFFF, 16'h0, 16'h0000, 1'b1, 1'b0);
      send_lit(OP_NOT, 16'hAAAA, 16'h0, 16'h5555, 1'b0, 1'b0);
      send_lit(OP_NOT, 16'h3CC3, 16'h0, 16'hC33C, 1'b0, 1'b1);
      send_lit(OP_NOT, 16'h1234, 16'h0, 16'hEDCB, 1'b0, 1'b1);

      // All eight ops back-to-back
      got_q.delete();
      for (int i = 0; i < 8; i++) begin
         op = 3'(i); a = 16'h00FF; b = 16'h0F0F; in_valid = 1'b1;
         @(negedge clk);
         chk("b2b_in_ready", in_ready, 1'b1);
         step();
      end
      in_valid = 1'b0;
      repeat (4) step();
      chk("b2b_count", got_q.size(), 8);
      for (int i = 0; i < 8 && i < got_q.size(); i++) begin
         chk("b2b_out", got_q[i].d, lit8[i]);
         if (i > 0) chk("b2b_spacing", got_q[i].cyc - got_q[i-1].cyc, 1);
      end

      // Backpressure: two accepted, third refused until the consumer moves
      strict_lat = 1'b0;
      got_q.delete();
      out_ready = 1'b0;
      push_item(OP_NOT, 16'h0001, 16'h0);
      push_item(OP_AND, 16'hF0F0, 16'hFF00);
      op = OP_XOR; a = 16'h1111; b = 16'h2222; in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("bp_in_ready_full", in_ready, 1'b0);
         chk("bp_out_valid", out_valid, 1'b1);
         chk("bp_out_head", out, 16'hFFFE);
         step();
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_third_accept", in_ready, 1'b1);
      step();
      in_valid = 1'b0;
      repeat (4) step();
      chk("bp_count", got_q.size(), 3);
      if (got_q.size() == 3) begin
         chk("bp_order0", got_q[0].d, 16'hFFFE);
         chk("bp_order1", got_q[1].d, 16'hF000);
         chk("bp_order2", got_q[2].d, 16'h3333);
      end

      // Full pipe with simultaneous in/out transfers
      got_q.delete();
      out_ready = 1'b0;
      push_item(OP_OR, 16'h1200, 16'h0034);
      push_item(OP_NOR, 16'h0F00, 16'h00F0);
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         op = 3'(i % 8); a = 16'(i * 16'h1357); b = 16'hA5A5; in_valid = 1'b1;
         @(negedge clk);
         chk("full_in_ready", in_ready, 1'b1);
         chk("full_out_valid", out_valid, 1'b1);
         step();
      end
      in_valid = 1'b0;
      repeat (4) step();
      chk("full_count", got_q.size(), 12);
      if (got_q.size() == 12) begin
         chk("full_first", got_q[0].d, 16'h1234);
         chk("full_second", got_q[1].d, 16'hF00F);
         chk("full_span", got_q[11].cyc - got_q[0].cyc, 11);
      end

      // Reset with two results in flight; a transfer presented during reset is dropped
      got_q.delete();
      out_ready = 1'b0;
      push_item(OP_PASS, 16'h1111, 16'h0);
      push_item(OP_PASS, 16'h2222, 16'h0);
      rst = 1'b1; in_valid = 1'b1; op = OP_PASS; a = 16'h7777; out_ready = 1'b1;
      step();
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      @(negedge clk);
      chk("rst2_out_valid", out_valid, 1'b0);
      chk("rst2_out", out, 16'h0);
      chk("rst2_zero", out_zero, 1'b0);
      chk("rst2_neg", out_neg, 1'b0);
      chk("rst2_in_ready", in_ready, 1'b1);
      step();
      op = OP_PASS; a = 16'hBEEF; in_valid = 1'b1;
      @(negedge clk);
      chk("rst2_first_accept", in_ready, 1'b1);
      step();
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (5) step();
      chk("rst2_count", got_q.size(), 1);
      if (got_q.size() == 1) chk("rst2_value", got_q[0].d, 16'hBEEF);
      chk("leftover", exp_q.size(), 0);

      // 8-bit, single-stage instance
      s_op = OP_XOR; s_a = 8'h80; s_b = 8'h80; s_in_valid = 1'b1;
      @(negedge clk);
      chk("w8_in_ready", s_in_ready, 1'b1);
      chk("w8_idle", s_out_valid, 1'b0);
      step();
      s_op = OP_NOT; s_a = 8'h0F; s_b = 8'h00;
      @(negedge clk);
      chk("w8_valid", s_out_valid, 1'b1);
      chk("w8_out", s_out, 8'h00);
      chk("w8_zero", s_out_zero, 1'b1);
      chk("w8_neg", s_out_neg, 1'b0);
      step();
      s_in_valid = 1'b0;
      @(negedge clk);
      chk("w8_not_valid", s_out_valid, 1'b1);
      chk("w8_not_out", s_out, 8'hF0);
      chk("w8_not_zero", s_out_zero, 1'b0);
      chk("w8_not_neg", s_out_neg, 1'b1);
      step();
      @(negedge clk);
      chk("w8_drained", s_out_valid, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
